fsrc_tx_gearbox: RTL and testbench

Second-generation transmit fractional sample-rate converter core. It accepts a multi-channel parallel sample stream and inserts "hole" samples at positions set by a phase accumulator, so the output consumes fewer input samples than it emits. Compared with the first generation, it adds a per-channel/per-lane layout, a sample gearbox buffer, selectable fill modes, a hole-mask sideband and proper backpressure. It sits between the TX DMA/upack stream and the JESD transport layer, and is driven by an AXI register map.

---
 rtl/fsrc_pkg.sv | 23 ++
 rtl/fsrc_hole_gen.sv | 28 ++
 rtl/fsrc_tx_gearbox.sv | 205 ++++++++++++++++++++
 tb/tb_fsrc_tx_gearbox.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsrc_pkg.sv
// Shared types for the TX fractional sample-rate converter: FSM states,
// fill modes and the flat lane index used by the packed sample buses.
package fsrc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } fsrc_state_e;

    typedef enum logic [1:0] {
        FILL_REPEAT = 2'd0,
        FILL_ZERO   = 2'd1,
        FILL_VALUE  = 2'd2,
        FILL_RSVD   = 2'd3
    } fsrc_fill_e;

    // Lane (c,s) lives at [(c*spc+s)*NP +: NP] of a packed beat.
    function automatic int lane_idx(input int c, input int s, input int spc);
        return c * spc + s;
    endfunction

endpackage

// File: rtl/fsrc_hole_gen.sv
// Combinational hole-mask generator: lane s is a hole when the phase
// accumulator wraps between sample s and sample s+1 of the beat.
module fsrc_hole_gen #(
    parameter int SPC = 4,
    parameter int W   = 64
) (
    input  logic [W-1:0]   acc,
    input  logic [W-1:0]   add,
    output logic [SPC-1:0] holes,
    output logic [W-1:0]   next_acc
);

    // Extra headroom so acc + SPC*add never overflows before the compare.
    localparam int EW = W + $clog2(SPC + 1);

    logic [EW-1:0] sums [SPC+1];

    always_comb begin
        for (int s = 0; s <= SPC; s++) begin
            sums[s] = {{(EW-W){1'b0}}, acc} + EW'(s) * {{(EW-W){1'b0}}, add};
        end
        for (int s = 0; s < SPC; s++) begin
            holes[s] = sums[s+1][EW-1:W] > sums[s][EW-1:W];
        end
        next_acc = sums[SPC][W-1:0];
    end

endmodule

// File: rtl/fsrc_tx_gearbox.sv
// TX fractional SRC core: FSM, per-channel gearbox buffer with a shared
// occupancy count, hole fill muxing and a stallable output register.
module fsrc_tx_gearbox
    import fsrc_pkg::*;
#(
    parameter int NP          = 16,
    parameter int SPC         = 4,
    parameter int NUM_CH      = 4,
    parameter int ACCUM_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        accum_set,
    input  logic [ACCUM_WIDTH-1:0]      accum_set_val,
    input  logic [ACCUM_WIDTH-1:0]      accum_add_val,
    input  logic [1:0]                  fill_mode,
    input  logic [NP-1:0]               fill_value,
    input  logic                        s_axis_valid,
    output logic                        s_axis_ready,
    input  logic [NUM_CH*SPC*NP-1:0]    s_axis_data,
    output logic                        m_axis_valid,
    input  logic                        m_axis_ready,
    output logic [NUM_CH*SPC*NP-1:0]    m_axis_data,
    output logic [SPC-1:0]              m_axis_hole,
    output logic                        running,
    output logic [1:0]                  dbg_state
);

    // Handshakes: a beat transfers on any rising clk edge where valid and
    // ready are both high; valid never waits on ready, and while valid is
    // high without ready the payload (data, hole mask) is held unchanged.

    localparam int BD    = 2 * SPC;
    localparam int OCC_W = $clog2(BD + 1);
    localparam int DW    = NUM_CH * SPC * NP;

    fsrc_state_e            state_q, state_d;
    logic                   stop_pend_q, stop_pend_d;
    logic [ACCUM_WIDTH-1:0] acc_q, acc_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [NP-1:0]          buf_q  [NUM_CH][BD];
    logic [NP-1:0]          buf_d  [NUM_CH][BD];
    logic [NP-1:0]          hist_q [NUM_CH];
    logic [NP-1:0]          hist_d [NUM_CH];
    logic [DW-1:0]          data_q, data_d;
    logic [SPC-1:0]         hole_q, hole_d;
    logic                   valid_q, valid_d;
    logic                   ready_q, ready_d;

    logic [SPC-1:0]         gen_holes;
    logic [ACCUM_WIDTH-1:0] gen_next;
    logic [SPC-1:0]         holes_eff;
    logic [DW-1:0]          form_data;
    logic [NP-1:0]          prev, smp;
    logic                   hs, stop_req, run_form, accept, fire;
    int                     need, rm, keep, k;

    fsrc_hole_gen #(
        .SPC (SPC),
        .W   (ACCUM_WIDTH)
    ) u_hole_gen (
        .acc      (acc_q),
        .add      (accum_add_val),
        .holes    (gen_holes),
        .next_acc (gen_next)
    );

    always_comb begin
        hs       = valid_q && m_axis_ready;
        stop_req = stop || stop_pend_q;
        // A pending stop retires on this handshake, so the beat formed now
        // is already passthrough.
        run_form  = (state_q == ST_RUN) && !(stop_req && hs);
        holes_eff = run_form ? gen_holes : '0;
        need = SPC;
        for (int s = 0; s < SPC; s++) begin
            if (holes_eff[s]) need = need - 1;
        end
        accept = enable && s_axis_valid && ready_q && (int'(occ_q) <= SPC);
        fire   = enable && (!valid_q || m_axis_ready) && (int'(occ_q) >= need);
        rm     = fire ? need : 0;
        keep   = int'(occ_q) - rm;

        form_data = '0;
        prev      = '0;
        smp       = '0;
        k         = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            hist_d[c] = hist_q[c];
            prev      = hist_q[c];
            k         = 0;
            for (int s = 0; s < SPC; s++) begin
                smp = '0;
                if (holes_eff[s]) begin
                    case (fsrc_fill_e'(fill_mode))
                        FILL_REPEAT: smp = prev;
                        FILL_VALUE:  smp = fill_value;
                        default:     smp = '0;
                    endcase
                end else begin
                    smp = buf_q[c][k];
                    k   = k + 1;
                end
                form_data[lane_idx(c, s, SPC)*NP +: NP] = smp;
                prev = smp;
            end
            if (fire) hist_d[c] = prev;
            if (!enable) hist_d[c] = '0;
        end

        // Survivors shift down by the consumed count; a new beat lands
        // right behind them.
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < BD; i++) begin
                buf_d[c][i] = buf_q[c][i];
                if (i < keep) begin
                    if (i + rm < BD) buf_d[c][i] = buf_q[c][i+rm];
                end else if (accept && (i - keep) < SPC) begin
                    buf_d[c][i] = s_axis_data[lane_idx(c, i - keep, SPC)*NP +: NP];
                end
            end
        end

        occ_d = enable ? OCC_W'(int'(occ_q) + (accept ? SPC : 0) - rm) : '0;
        ready_d = enable && (int'(occ_d) <= SPC);

        data_d  = data_q;
        hole_d  = hole_q;
        valid_d = valid_q && !m_axis_ready;
        if (fire) begin
            data_d  = form_data;
            hole_d  = holes_eff;
            valid_d = 1'b1;
        end
        if (!enable) valid_d = 1'b0;

        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        acc_d       = acc_q;
        if (run_form && fire) acc_d = gen_next;
        if (!enable) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    stop_pend_d = 1'b0;
                    if (accum_set) acc_d = accum_set_val;
                    if (start && !stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stop_req && hs) begin
                        state_d     = ST_ARMED;
                        stop_pend_d = 1'b0;
                    end else if (stop) begin
                        stop_pend_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            acc_q       <= '0;
            occ_q       <= '0;
            data_q      <= '0;
            hole_q      <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                hist_q[c] <= '0;
                for (int i = 0; i < BD; i++) buf_q[c][i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            acc_q       <= acc_d;
            occ_q       <= occ_d;
            data_q      <= data_d;
            hole_q      <= hole_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            for (int c = 0; c < NUM_CH; c++) begin
                hist_q[c] <= hist_d[c];
                for (int i = 0; i < BD; i++) buf_q[c][i] <= buf_d[c][i];
            end
        end
    end

    assign s_axis_ready = ready_q;
    assign m_axis_valid = valid_q;
    assign m_axis_data  = data_q;
    assign m_axis_hole  = hole_q;
    assign running      = (state_q == ST_RUN);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_fsrc_tx_gearbox.sv
// Randomized bench for fsrc_tx_gearbox: a sample-queue reference model
// derives every output beat from the phase arithmetic and fill rules.
module tb_fsrc_tx_gearbox;
    import fsrc_pkg::*;

    localparam int NP  = 16;
    localparam int SPC = 4;
    localparam int NCH = 2;
    localparam int AW  = 16;
    localparam int DW  = NCH * SPC * NP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable, start, stop, accum_set;
    logic [AW-1:0] set_val, add_val;
    logic [1:0] fill_mode;
    logic [NP-1:0] fill_value;
    logic s_valid, s_ready, m_valid, m_ready, running;
    logic [DW-1:0] s_data, m_data;
    logic [SPC-1:0] m_hole;
    logic [1:0] dbg_state;

    fsrc_tx_gearbox #(.NP(NP), .SPC(SPC), .NUM_CH(NCH), .ACCUM_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
        .accum_set(accum_set), .accum_set_val(set_val), .accum_add_val(add_val),
        .fill_mode(fill_mode), .fill_value(fill_value),
        .s_axis_valid(s_valid), .s_axis_ready(s_ready), .s_axis_data(s_data),
        .m_axis_valid(m_valid), .m_axis_ready(m_ready), .m_axis_data(m_data),
        .m_axis_hole(m_hole), .running(running), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one queue entry holds sample index n of every channel.
    logic [NCH*NP-1:0] exp_q[$];
    logic [AW-1:0] ma;
    bit mrun, mstop;
    logic [NP-1:0] mhist [NCH];
    int rmode = 0;
    int rpat = 0;
    int rseq = 0;

    function automatic logic [SPC-1:0] holes_of(input logic [AW-1:0] a, input logic [AW-1:0] d);
        logic [SPC-1:0] h;
        longint lo, hi;
        for (int s = 0; s < SPC; s++) begin
            lo = (longint'(a) + longint'(s) * longint'(d)) / (longint'(1) << AW);
            hi = (longint'(a) + longint'(s + 1) * longint'(d)) / (longint'(1) << AW);
            h[s] = hi > lo;
        end
        return h;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        for (int c = 0; c < NCH; c++) mhist[c] = '0;
        mrun = 0;
        mstop = 0;
    endtask

    task automatic model_beat();
        logic [SPC-1:0] h;
        logic [NCH*NP-1:0] pick [SPC];
        logic [DW-1:0] ed;
        logic [NP-1:0] pv, sm;
        int need, k;
        h = mrun ? holes_of(ma, add_val) : '0;
        need = SPC - $countones(h);
        if (exp_q.size() < need) begin
            check_eq("underflow", DW'(exp_q.size()), DW'(need));
            return;
        end
        for (int i = 0; i < need; i++) pick[i] = exp_q.pop_front();
        ed = '0;
        for (int c = 0; c < NCH; c++) begin
            pv = mhist[c];
            k = 0;
            for (int s = 0; s < SPC; s++) begin
                if (h[s]) sm = (fill_mode == 2'd0) ? pv : (fill_mode == 2'd2) ? fill_value : '0;
                else begin
                    sm = pick[k][c*NP +: NP];
                    k++;
                end
                ed[(c*SPC+s)*NP +: NP] = sm;
                pv = sm;
            end
            mhist[c] = pv;
        end
        check_eq("beat_data", m_data, ed);
        check_eq("beat_hole", DW'(m_hole), DW'(h));
        if (mrun) ma = ma + AW'(SPC) * add_val;
        if (mstop) begin
            mrun = 0;
            mstop = 0;
        end
    endtask

    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic [SPC-1:0] prev_hole;

    always @(negedge clk) begin
        if (reset || !enable) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", DW'(m_valid), DW'(1));
                check_eq("hold_data", m_data, prev_data);
                check_eq("hold_hole", DW'(m_hole), DW'(prev_hole));
            end
            if (s_valid && s_ready) begin
                for (int s = 0; s < SPC; s++) begin
                    logic [NCH*NP-1:0] e;
                    for (int c = 0; c < NCH; c++) e[c*NP +: NP] = s_data[(c*SPC+s)*NP +: NP];
                    exp_q.push_back(e);
                end
            end
            if (m_valid && m_ready) model_beat();
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_hole = m_hole;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    m_ready = (rpat % 4 == 0) || (rpat % 4 == 3);
                    rpat++;
                end
                default: m_ready = 1'b1;
            endcase
        end
    end

    function automatic logic [DW-1:0] make_beat(input bit ramp);
        logic [DW-1:0] d;
        for (int s = 0; s < SPC; s++) begin
            for (int c = 0; c < NCH; c++)
                d[(c*SPC+s)*NP +: NP] = ramp ? NP'(c * 256 + rseq) : NP'($urandom);
            rseq++;
        end
        return d;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int n, input bit ramp);
        for (int b = 0; b < n; b++) begin
            int guard = 0;
            bit ok = 0;
            if (!ramp && $urandom_range(0, 3) == 0) cyc(1);
            s_data = make_beat(ramp);
            s_valid = 1'b1;
            while (!ok && guard < 300) begin
                @(negedge clk);
                ok = s_ready;
                guard++;
            end
            if (!ok) check_eq("accept_timeout", DW'(0), DW'(1));
            cyc(1);
            s_valid = 1'b0;
        end
    endtask

    task automatic drain();
        logic [SPC-1:0] h;
        rmode = 0;
        s_valid = 1'b0;
        cyc(12);
        @(negedge clk);
        check_eq("drain_valid", DW'(m_valid), DW'(0));
        h = mrun ? holes_of(ma, add_val) : '0;
        check_eq("drain_residual", DW'(exp_q.size() < (SPC - $countones(h))), DW'(1));
        cyc(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        mrun = 1;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        mstop = 1;
    endtask

    task automatic set_accum(input logic [AW-1:0] v);
        set_val = v;
        accum_set = 1'b1;
        cyc(1);
        accum_set = 1'b0;
        ma = v;
    endtask

    task automatic flush();
        enable = 1'b0;
        cyc(2);
        model_clear();
        enable = 1'b1;
        cyc(3);
    endtask

    initial begin
        int lat;
        bit ok;
        reset = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; accum_set = 1'b0;
        set_val = '0; add_val = '0; fill_mode = 2'd1; fill_value = '0;
        s_valid = 1'b0; s_data = '0;
        ma = '0;
        model_clear();
        cyc(3);
        @(negedge clk);
        check_eq("rst_s_ready", DW'(s_ready), DW'(0));
        check_eq("rst_m_valid", DW'(m_valid), DW'(0));
        check_eq("rst_m_data", m_data, '0);
        check_eq("rst_m_hole", DW'(m_hole), DW'(0));
        check_eq("rst_running", DW'(running), DW'(0));
        cyc(1);
        reset = 1'b0;
        enable = 1'b1;
        cyc(3);
        @(negedge clk);
        check_eq("ready_up", DW'(s_ready), DW'(1));
        check_eq("armed", DW'(dbg_state), DW'(ST_ARMED));

        // Passthrough latency, then a ramp stream.
        cyc(1);
        s_data = make_beat(1);
        s_valid = 1'b1;
        @(negedge clk);
        check_eq("lat_ready", DW'(s_ready), DW'(1));
        cyc(1);
        s_valid = 1'b0;
        lat = 0;
        ok = 0;
        while (!ok && lat < 10) begin
            @(negedge clk);
            lat++;
            ok = m_valid;
        end
        check_eq("latency", DW'(lat), DW'(2));
        cyc(1);
        send_beats(8, 1);
        drain();

        // RUN with D=0x4000 from A=0, zero fill, random backpressure.
        flush();
        add_val = 16'h4000;
        fill_mode = 2'd1;
        set_accum(16'h0000);
        pulse_start();
        @(negedge clk);
        check_eq("run_entered", DW'(running), DW'(1));
        cyc(1);
        rmode = 1;
        send_beats(10, 0);
        drain();

        // Stop while idle in RUN: one more RUN beat, then passthrough.
        pulse_stop();
        send_beats(6, 0);
        drain();
        check_eq("stopped", DW'(running), DW'(0));

        // Repeat fill from A=0 and from A=0xE000.
        fill_mode = 2'd0;
        set_accum(16'h0000);
        pulse_start();
        rmode = 1;
        send_beats(5, 0);
        drain();
        pulse_stop();
        send_beats(2, 0);
        drain();
        set_accum(16'hE000);
        pulse_start();
        rmode = 1;
        send_beats(8, 0);
        drain();
        pulse_stop();
        send_beats(2, 0);
        drain();

        // start and stop together in ARMED leaves the core ARMED.
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        check_eq("start_stop_run", DW'(running), DW'(0));
        check_eq("start_stop_state", DW'(dbg_state), DW'(ST_ARMED));
        cyc(1);

        // A=0x8000, D=0x8000, constant fill, 1,0,0,1 ready pattern.
        add_val = 16'h8000;
        fill_mode = 2'd2;
        fill_value = NP'($urandom);
        set_accum(16'h8000);
        pulse_start();
        rpat = 0;
        rmode = 2;
        send_beats(12, 0);
        drain();

        // Reset in the middle of a running stream.
        rmode = 1;
        send_beats(3, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_valid", DW'(m_valid), DW'(0));
        check_eq("mid_rst_data", m_data, '0);
        check_eq("mid_rst_hole", DW'(m_hole), DW'(0));
        check_eq("mid_rst_ready", DW'(s_ready), DW'(0));
        check_eq("mid_rst_running", DW'(running), DW'(0));
        model_clear();
        ma = '0;
        rmode = 0;
        cyc(1);
        reset = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
